leiwand_rv32_uart_tx: RTL and testbench
=======================================

Name: leiwand_rv32_uart_tx

Overview:
Memory-mapped UART transmitter that sits on the core's native memory bus (valid/ready/addr/wdata/rdata/wen) as a bus responder, beside simple_mem. The core writes bytes into a TX FIFO. An 8N1 serializer drains the FIFO onto a single tx line at a programmable bit period. It gives the test SoC a character output path, so software can print and the bench can decode the output.

Parameters:
BASE_ADDR, 32'h10000000, byte address of register window (16-byte aligned)
FIFO_DEPTH, 8, TX FIFO entries; power of 2, min 2
DEFAULT_BAUDDIV, 16'd433, reset value of BAUDDIV; bit period = BAUDDIV+1 clk cycles

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
valid  in  1  core request; held until ready seen
ready  out  1  one-cycle response pulse
addr  in  32  byte address
wdata  in  32  write data
wen  in  4  byte write enables; 4'b0000 = read
rdata  out  32  read data; valid while ready=1, else 32'h0
tx  out  1  serial output, idle high

Behaviour:
- Select: sel = valid && addr[31:4]==BASE_ADDR[31:4]. Unselected requests are ignored: no ready, no side effects.
- Handshake: if sel && !ready && request is acceptable, ready=1 on the next edge and the access takes effect on that same edge. ready is forced to 0 the following cycle. One request gives exactly one pulse.
- Register map (addr[3:2]):
  - 0x0 TXDATA: write with wen[0] pushes wdata[7:0]. Write with wen[0]=0 is acked with no push. Read returns 0.
  - 0x4 STATUS (RO): [0] full, [1] empty, [2] busy (state!=IDLE or !empty), [$clog2(FIFO_DEPTH)+8:8] count. Writes are acked and ignored.
  - 0x8 BAUDDIV: [15:0] RW. wen[0] writes the low byte, wen[1] the high byte.
  - 0xC: reserved. Reads 0; writes acked and ignored.
- FIFO full stall: a TXDATA write with wen[0] is acceptable only if count<FIFO_DEPTH in that cycle. Otherwise ready is withheld and the request stays pending until space frees. A pop in the same cycle does not admit the push; it is admitted the next cycle.
- FIFO: read/write pointers of width $clog2(FIFO_DEPTH) wrap modulo depth. Count has one extra bit. Simultaneous push and pop leaves count unchanged.
- Serializer FSM (states IDLE, START, DATA, STOP):
  - IDLE: tx=1. If !empty: pop into shift reg, latch BAUDDIV into bit counter limit, go to START.
  - START: tx=0 for BAUDDIV+1 cycles, then DATA.
  - DATA: 8 bits LSB first, each BAUDDIV+1 cycles. Bit index 0..7, then STOP.
  - STOP: tx=1 for BAUDDIV+1 cycles, then IDLE. IDLE may pop the next byte on the cycle after STOP ends, giving a 1-cycle inter-frame gap.
- tx is registered. For a push into an empty FIFO with the FSM in IDLE, tx falls on the 2nd rising edge after the edge that asserted ready.
- A BAUDDIV write mid-frame does not affect the current frame; it applies from the next frame.
- Reset values: ready=0, rdata=0, tx=1, FIFO empty, state IDLE, BAUDDIV=DEFAULT_BAUDDIV.
- Reset mid-frame: the frame is abandoned, FIFO contents are discarded, and tx=1 from the reset edge onward. A pending bus request is dropped without ready.

Optional Feature:
LEIWAND_RV32_UART_TX_IRQ_EN
- Defined:
  - Adds output port irq (1 bit, reset 0).
  - Register 0xC IRQ_EN [0] is RW.
  - irq is registered: irq = IRQ_EN[0] && empty && state==IDLE.
- Undefined:
  - No irq port.
  - 0xC behaves as reserved.

Test Plan:
- Reset, then read 0x4 and 0x8 -> STATUS=32'h00000002; BAUDDIV=433; tx=1 throughout; each read gets exactly one ready pulse, 1 cycle after valid.
- Write BAUDDIV=3, then TXDATA=0x55 -> tx: 0 for 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then stop 1 for 4 cycles. Frame is 40 cycles; STATUS busy=1 during the frame, 0 after.
- BAUDDIV=99, 10 back-to-back TXDATA writes (depth 8) -> writes 1-9 acked promptly (1 in shifter, 8 in FIFO), STATUS full=1, count=8. Write 10 ready is withheld until the first frame's STOP ends, acked 2 cycles after the pop. All 10 bytes are decoded in order.
- valid with addr=BASE_ADDR+0x10 for 20 cycles -> ready stays 0, STATUS unchanged, tx idle.
- BAUDDIV=7, write 0xA5, pulse reset 1 cycle during DATA bit 3 -> tx=1 from the reset edge; STATUS=0x2 and BAUDDIV=433 after reset; no tx transitions for 200 cycles.
- With LEIWAND_RV32_UART_TX_IRQ_EN: IRQ_EN=1 gives irq=1. Write a byte -> irq=0 while busy, irq=1 one cycle after return to IDLE. IRQ_EN=0 -> irq=0 the cycle after the write ack.

Source files
------------

// File: rtl/leiwand_rv32_uart_tx.sv
// leiwand_rv32_uart_tx: memory-mapped 8N1 UART transmitter on the core's
// native valid/ready bus. The core pushes bytes into a small TX FIFO and a
// serializer drains them onto tx at a programmable bit period.
// Optional feature macro: LEIWAND_RV32_UART_TX_IRQ_EN (adds irq output and
// an IRQ_EN register at offset 0xC).
module leiwand_rv32_uart_tx #(
  parameter logic [31:0] BASE_ADDR       = 32'h1000_0000,
  parameter int          FIFO_DEPTH      = 8,
  parameter logic [15:0] DEFAULT_BAUDDIV = 16'd433
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid,
  output logic        ready,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wen,
  output logic [31:0] rdata,
  output logic        tx
`ifdef LEIWAND_RV32_UART_TX_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int            PW      = $clog2(FIFO_DEPTH);
  localparam logic [PW:0]   DEPTH_C = FIFO_DEPTH[PW:0];
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [PW:0]   CNT_ONE = (PW + 1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  // Bus-side registers
  logic        ready_q, ready_d;
  logic [31:0] rdata_q, rdata_d;
  logic [15:0] baud_q, baud_d;
`ifdef LEIWAND_RV32_UART_TX_IRQ_EN
  logic        irq_en_q, irq_en_d;
  logic        irq_q;
`endif

  // FIFO storage and bookkeeping
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;

  // Serializer state
  state_t      state_q;
  logic [7:0]  shift_q;
  logic [15:0] lim_q;
  logic [15:0] cnt_q;
  logic [2:0]  bit_q;
  logic        tx_q;

  logic        sel, accept, push, pop, full, empty, busy, is_read;
  logic [1:0]  reg_idx;
  logic [31:0] status;

  // Address bits below word granularity and the upper data bytes are not
  // decoded by any register.
  logic unused_bits;
  assign unused_bits = ^{addr[1:0], wdata[31:16]};

  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  assign busy    = (state_q != S_IDLE) || !empty;
  assign reg_idx = addr[3:2];
  assign is_read = (wen == 4'b0000);
  assign sel     = valid && (addr[31:4] == BASE_ADDR[31:4]);
  // The serializer takes a byte whenever it is idle and the FIFO has one.
  assign pop     = (state_q == S_IDLE) && !empty;

  // A TXDATA push is admitted only against the count seen this cycle, so a
  // pop in the same cycle never makes room for it until the next cycle.
  assign accept = sel && !ready_q &&
                  !((reg_idx == 2'd0) && wen[0] && full);

  // STATUS register image
  always_comb begin
    status          = '0;
    status[0]       = full;
    status[1]       = empty;
    status[2]       = busy;
    status[PW+8:8]  = count_q;
  end

  // Bus decode: response pulse, read data and register/FIFO updates
  always_comb begin
    ready_d  = 1'b0;
    rdata_d  = '0;
    baud_d   = baud_q;
    push     = 1'b0;
`ifdef LEIWAND_RV32_UART_TX_IRQ_EN
    irq_en_d = irq_en_q;
`endif
    if (accept) begin
      ready_d = 1'b1;
      case (reg_idx)
        2'd0: push = wen[0];
        2'd1: if (is_read) rdata_d = status;
        2'd2: begin
          if (is_read) rdata_d = {16'h0000, baud_q};
          if (wen[0]) baud_d[7:0]  = wdata[7:0];
          if (wen[1]) baud_d[15:8] = wdata[15:8];
        end
        2'd3: begin
`ifdef LEIWAND_RV32_UART_TX_IRQ_EN
          if (is_read) rdata_d = {31'h0, irq_en_q};
          if (wen[0])  irq_en_d = wdata[0];
`endif
        end
      endcase
    end
  end

  // FIFO pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (push && !pop)      count_d = count_q + CNT_ONE;
    else if (pop && !push) count_d = count_q - CNT_ONE;
  end

  // Control registers: bus response, BAUDDIV and FIFO bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q  <= 1'b0;
      rdata_q  <= '0;
      baud_q   <= DEFAULT_BAUDDIV;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
`ifdef LEIWAND_RV32_UART_TX_IRQ_EN
      irq_en_q <= 1'b0;
`endif
    end else begin
      ready_q  <= ready_d;
      rdata_q  <= rdata_d;
      baud_q   <= baud_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
`ifdef LEIWAND_RV32_UART_TX_IRQ_EN
      irq_en_q <= irq_en_d;
`endif
    end
  end

  // FIFO storage write (data only, no reset)
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= wdata[7:0];
  end

  // Serializer FSM; tx is registered so it follows the state by one cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          tx_q <= 1'b1;
          if (pop) begin
            shift_q <= fifo_mem[rd_ptr_q];
            lim_q   <= baud_q;
            cnt_q   <= '0;
            state_q <= S_START;
          end
        end
        S_START: begin
          tx_q <= 1'b0;
          if (cnt_q == lim_q) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            state_q <= S_DATA;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        S_DATA: begin
          tx_q <= shift_q[0];
          if (cnt_q == lim_q) begin
            cnt_q   <= '0;
            shift_q <= {1'b0, shift_q[7:1]};
            if (bit_q == 3'd7) state_q <= S_STOP;
            else               bit_q   <= bit_q + 3'd1;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        S_STOP: begin
          tx_q <= 1'b1;
          if (cnt_q == lim_q) begin
            cnt_q   <= '0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef LEIWAND_RV32_UART_TX_IRQ_EN
  // Registered idle interrupt: enabled, nothing queued and serializer idle
  always_ff @(posedge clk) begin
    if (reset) irq_q <= 1'b0;
    else       irq_q <= irq_en_q && empty && (state_q == S_IDLE);
  end
  assign irq = irq_q;
`endif

  assign ready = ready_q;
  assign rdata = rdata_q;
  assign tx    = tx_q;

endmodule

// File: tb/tb_leiwand_rv32_uart_tx.sv
// Bench for leiwand_rv32_uart_tx: register vectors from a table, hand-written
// frame / stall / reset sequences, and a UART decoder fed by a byte
// scoreboard.
module tb_leiwand_rv32_uart_tx;

  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid;
  logic        ready;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wen;
  logic [31:0] rdata;
  logic        tx;
`ifdef LEIWAND_RV32_UART_TX_IRQ_EN
  logic        irq;
`endif

  leiwand_rv32_uart_tx dut (
    .clk   (clk),
    .reset (reset),
    .valid (valid),
    .ready (ready),
    .addr  (addr),
    .wdata (wdata),
    .wen   (wen),
    .rdata (rdata),
    .tx    (tx)
`ifdef LEIWAND_RV32_UART_TX_IRQ_EN
    ,
    .irq   (irq)
`endif
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] sb_q[$];
  int         cur_div = 433;
  bit         dec_en = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One bus transaction; returns read data and cycles-to-ready, then checks
  // that ready dropped the following cycle.
  task automatic bus(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd,
                     input int limit, output logic [31:0] rd, output int lat);
    bit ok = 1'b0;
    @(negedge clk);
    valid = 1'b1; addr = a; wen = we; wdata = wd;
    lat = 0; rd = '0;
    while (lat < limit) begin
      @(posedge clk); #1;
      lat++;
      if (ready === 1'b1) begin ok = 1'b1; rd = rdata; break; end
    end
    valid = 1'b0; wen = 4'h0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL bus_timeout actual=no_ready required=ready addr=%h", a);
    end else begin
      @(posedge clk); #1;
      chk("ready_single_pulse", {31'h0, ready}, 32'h0);
    end
  endtask

  // UART decoder: samples mid-bit on falling clock edges and compares each
  // received byte against the scoreboard.
  initial begin : decoder
    logic prev = 1'b1;
    logic [7:0] b;
    logic stp;
    int div;
    forever begin
      @(negedge clk);
      if (prev === 1'b1 && tx === 1'b0) begin
        div = cur_div;
        repeat ((div + 1) / 2) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
          repeat (div + 1) @(negedge clk);
          b[k] = tx;
        end
        repeat (div + 1) @(negedge clk);
        stp = tx;
        if (dec_en) begin
          if (sb_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL uart_unexpected_byte actual=%h required=none", b);
          end else begin
            chk("uart_byte", {24'h0, b}, {24'h0, sb_q.pop_front()});
            chk("uart_stop", {31'h0, stp}, 32'h1);
          end
        end
      end
      prev = tx;
    end
  end

  typedef struct {
    logic [3:0]  off;
    logic [3:0]  we;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  initial begin : main
    vec_t        vecs[15];
    logic [31:0] rd;
    int          lat;
    int          bad;
    int          n;

    vecs[0]  = '{4'h4, 4'h0, 32'h0,         32'h0000_0002};
    vecs[1]  = '{4'h8, 4'h0, 32'h0,         32'd433};
    vecs[2]  = '{4'h8, 4'h2, 32'h0000_0A00, 32'h0};
    vecs[3]  = '{4'h8, 4'h0, 32'h0,         32'h0000_0AB1};
    vecs[4]  = '{4'h8, 4'h1, 32'hFFFF_FF03, 32'h0};
    vecs[5]  = '{4'h8, 4'h0, 32'h0,         32'h0000_0A03};
    vecs[6]  = '{4'h8, 4'hF, 32'hABCD_0003, 32'h0};
    vecs[7]  = '{4'h8, 4'h0, 32'h0,         32'h0000_0003};
    vecs[8]  = '{4'h4, 4'hF, 32'hFFFF_FFFF, 32'h0};
    vecs[9]  = '{4'h4, 4'h0, 32'h0,         32'h0000_0002};
    vecs[10] = '{4'h0, 4'h0, 32'h0,         32'h0};
    vecs[11] = '{4'h0, 4'hE, 32'h0000_00AA, 32'h0};
    vecs[12] = '{4'h4, 4'h0, 32'h0,         32'h0000_0002};
    vecs[13] = '{4'hC, 4'hF, 32'h0,         32'h0};
    vecs[14] = '{4'hC, 4'h0, 32'h0,         32'h0};

    valid = 1'b0; addr = '0; wdata = '0; wen = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", {31'h0, ready}, 32'h0);
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_tx", {31'h0, tx}, 32'h1);
    @(negedge clk); reset = 1'b0;

    // Register map vectors
    for (int i = 0; i < 15; i++) begin
      bus(BASE + {28'h0, vecs[i].off}, vecs[i].we, vecs[i].wd, 20, rd, lat);
      chk("vec_latency", lat, 1);
      if (vecs[i].we == 4'h0) chk("vec_rdata", rd, vecs[i].exp);
    end
    chk("tx_idle_after_regs", {31'h0, tx}, 32'h1);

    // Single frame at BAUDDIV=3, waveform checked cycle by cycle
    cur_div = 3;
    sb_q.push_back(8'h55);
    bus(BASE, 4'h1, 32'h55, 20, rd, lat);
    chk("tx_still_high", {31'h0, tx}, 32'h1);
    fork
      begin
        logic [7:0] v = 8'h55;
        logic e;
        for (int j = 0; j < 40; j++) begin
          @(posedge clk); #1;
          if (j < 4)       e = 1'b0;
          else if (j < 36) e = v[(j - 4) / 4];
          else             e = 1'b1;
          chk("frame_wave", {31'h0, tx}, {31'h0, e});
        end
      end
      begin
        logic [31:0] r2;
        int l2;
        repeat (10) @(negedge clk);
        bus(BASE + 32'h4, 4'h0, 32'h0, 20, r2, l2);
        chk("status_busy", r2, 32'h0000_0006);
      end
    join
    bus(BASE + 32'h4, 4'h0, 32'h0, 20, rd, lat);
    chk("status_after_frame", rd, 32'h0000_0002);

    // FIFO full stall at BAUDDIV=99
    bus(BASE + 32'h8, 4'h3, 32'd99, 20, rd, lat);
    cur_div = 99;
    for (int i = 0; i < 9; i++) begin
      sb_q.push_back(8'h30 + 8'(i));
      bus(BASE, 4'h1, 32'h30 + i, 20, rd, lat);
      chk("burst_write_latency", lat, 1);
    end
    bus(BASE + 32'h4, 4'h0, 32'h0, 20, rd, lat);
    chk("status_full", rd, 32'h0000_0805);
    sb_q.push_back(8'h39);
    bus(BASE, 4'h1, 32'h39, 3000, rd, lat);
    chk("stall_withheld", {31'h0, (lat > 500 && lat < 1100)}, 32'h1);
    n = 0;
    while (sb_q.size() != 0 && n < 12000) begin @(posedge clk); n++; end
    chk("burst_drained", sb_q.size(), 0);
    repeat (120) @(posedge clk);

    // Unselected window: ready never asserted, no push
    bad = 0;
    @(negedge clk);
    valid = 1'b1; addr = BASE + 32'h10; wen = 4'hF; wdata = 32'h77;
    repeat (20) begin @(posedge clk); #1; if (ready !== 1'b0) bad++; end
    valid = 1'b0; wen = 4'h0;
    chk("unselected_no_ready", bad, 0);
    bus(BASE + 32'h4, 4'h0, 32'h0, 20, rd, lat);
    chk("unselected_status", rd, 32'h0000_0002);
    chk("unselected_tx", {31'h0, tx}, 32'h1);

    // Reset in the middle of a frame (DATA bit 3 at BAUDDIV=7)
    dec_en = 1'b0;
    bus(BASE + 32'h8, 4'h3, 32'd7, 20, rd, lat);
    cur_div = 7;
    bus(BASE, 4'h1, 32'hA5, 20, rd, lat);
    repeat (34) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midframe_reset_tx", {31'h0, tx}, 32'h1);
    chk("midframe_reset_ready", {31'h0, ready}, 32'h0);
    reset = 1'b0;
    bus(BASE + 32'h4, 4'h0, 32'h0, 20, rd, lat);
    chk("reset_status", rd, 32'h0000_0002);
    bus(BASE + 32'h8, 4'h0, 32'h0, 20, rd, lat);
    chk("reset_bauddiv", rd, 32'd433);
    bad = 0;
    repeat (200) begin @(negedge clk); if (tx !== 1'b1) bad++; end
    chk("quiet_after_reset", bad, 0);

`ifdef LEIWAND_RV32_UART_TX_IRQ_EN
    // Idle interrupt
    dec_en = 1'b1;
    bus(BASE + 32'h8, 4'h3, 32'd3, 20, rd, lat);
    cur_div = 3;
    bus(BASE + 32'hC, 4'h1, 32'h1, 20, rd, lat);
    bus(BASE + 32'hC, 4'h0, 32'h0, 20, rd, lat);
    chk("irq_en_readback", rd, 32'h1);
    chk("irq_idle_high", {31'h0, irq}, 32'h1);
    sb_q.push_back(8'h3C);
    bus(BASE, 4'h1, 32'h3C, 20, rd, lat);
    chk("irq_low_busy", {31'h0, irq}, 32'h0);
    n = 0;
    while (irq !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
    chk("irq_return_cycle", n, 41);
    bus(BASE + 32'hC, 4'h1, 32'h0, 20, rd, lat);
    chk("irq_disabled", {31'h0, irq}, 32'h0);
    n = 0;
    while (sb_q.size() != 0 && n < 500) begin @(posedge clk); n++; end
`endif

    chk("scoreboard_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
